// File: rtl/alu_issue_ctrl.sv
// Issue controller: sequences 8-bit instructions through a 4-entry register file into an external combinational ALU.
// Optional macro ALU_ISSUE_STICKY_OVF_EN makes overflow_flag sticky until reset.
module alu_issue_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [7:0]       instr,
  output logic             instr_ready,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             wb_valid,
  output logic [1:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             zero_flag,
  output logic             overflow_flag,
  input  logic [1:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, IMM} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [1:0]       rd_q, rs_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             rz_q, rv_q;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic             wb_valid_q;
  logic [1:0]       wb_addr_q;
  logic [WIDTH-1:0] wb_data_q;
  logic             zero_q, ovf_q;
  logic             ovf_d;
  logic             xfer;

  assign xfer = instr_valid && instr_ready;

`ifdef ALU_ISSUE_STICKY_OVF_EN
  assign ovf_d = ovf_q | rv_q;
`else
  assign ovf_d = rv_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_opcode  = 3'b000;
    alu_a       = '0;
    alu_b       = '0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = (instr[7:5] == OP_LDI) ? IMM : READ;
      end
      READ: state_d = EXEC;
      EXEC: begin
        alu_opcode = op_q;
        alu_a      = a_q;
        alu_b      = b_q;
        state_d    = WB;
      end
      WB:   state_d = IDLE;
      IMM: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = WB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      rz_q       <= 1'b0;
      rv_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (xfer) begin
          op_q <= instr[7:5];
          rd_q <= instr[4:3];
          rs_q <= instr[2:1];
        end
        // Operands are snapshotted here, so rd==rs sees the pre-write value.
        READ: begin
          a_q <= regs_q[rd_q];
          b_q <= regs_q[rs_q];
        end
        EXEC: begin
          res_q <= alu_res;
          rz_q  <= alu_zero;
          rv_q  <= alu_overflow;
        end
        IMM: if (xfer) begin
          res_q <= WIDTH'(instr);
          rz_q  <= (instr == 8'h00);
          rv_q  <= 1'b0;
        end
        WB: begin
          regs_q[rd_q] <= res_q;
          wb_valid_q   <= 1'b1;
          wb_addr_q    <= rd_q;
          wb_data_q    <= res_q;
          zero_q       <= rz_q;
          ovf_q        <= ovf_d;
        end
        default: ;
      endcase
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign zero_flag     = zero_q;
  assign overflow_flag = ovf_q;
  assign dbg_data      = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small combinational ALU model attached.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [2:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_res;
  logic       alu_zero, alu_overflow;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       zero_flag, overflow_flag;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int total = 0;
  int bad   = 0;
  logic ovf_model = 1'b0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // External ALU: 000 ADD (signed overflow), 001 AND, 010 NOT a, others yield 0.
  always_comb begin
    alu_res      = 8'h00;
    alu_overflow = 1'b0;
    case (alu_opcode)
      3'b000: begin
        alu_res      = alu_a + alu_b;
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_res[7] != alu_a[7]);
      end
      3'b001:  alu_res = alu_a & alu_b;
      3'b010:  alu_res = ~alu_a;
      default: alu_res = 8'h00;
    endcase
    alu_zero = (alu_res == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Present a byte at a negedge and hold it until accepted (bounded).
  task automatic xfer(input logic [7:0] b);
    int n;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = b;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_ready", instr_ready, 1'b1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 8'h00;
  endtask

  task automatic imm_finish(input logic [1:0] rd, input logic [7:0] imm);
    xfer(imm);
    @(posedge clk);
    @(negedge clk);
    if (!STICKY) ovf_model = 1'b0;
    chk("ldi_wb_valid", wb_valid, 1'b1);
    chk("ldi_wb_addr", wb_addr, rd);
    chk("ldi_wb_data", wb_data, imm);
    chk("ldi_zero", zero_flag, imm == 8'h00);
    chk("ldi_ovf", overflow_flag, ovf_model);
    chk_reg("ldi_reg", rd, imm);
    @(negedge clk);
    chk("ldi_wb_pulse", wb_valid, 1'b0);
  endtask

  task automatic ldi(input logic [1:0] rd, input logic [7:0] imm);
    xfer({3'b111, rd, 2'b00, 1'b0});
    imm_finish(rd, imm);
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] eres,
                        input logic ez, input logic ev);
    xfer({op, rd, rs, 1'b0});
    chk("read_ready", instr_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("exec_opcode", alu_opcode, op);
    chk("exec_a", alu_a, ea);
    chk("exec_b", alu_b, eb);
    chk("exec_no_wb", wb_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("wb_state_opcode", alu_opcode, 3'b000);
    chk("wb_state_ready", instr_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    ovf_model = STICKY ? (ovf_model | ev) : ev;
    chk("alu_wb_valid", wb_valid, 1'b1);
    chk("alu_wb_addr", wb_addr, rd);
    chk("alu_wb_data", wb_data, eres);
    chk("alu_zero", zero_flag, ez);
    chk("alu_ovf", overflow_flag, ovf_model);
    chk("alu_ready_after", instr_ready, 1'b1);
    chk_reg("alu_reg", rd, eres);
    @(negedge clk);
    chk("alu_wb_pulse", wb_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cnt, wb_cnt, acc_cnt, last_acc;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 8'h00;
    dbg_addr    = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 8'h00);
    chk("rst_wb_addr", wb_addr, 2'd0);
    chk("rst_zero", zero_flag, 1'b0);
    chk("rst_ovf", overflow_flag, 1'b0);
    chk("rst_opcode", alu_opcode, 3'b000);
    rst_n = 1'b1;
    chk("rst_ready", instr_ready, 1'b1);
    for (int i = 0; i < 4; i++) chk_reg("rst_reg", 2'(i), 8'h00);

    // Basic ADD: 5 + 3
    ldi(2'd1, 8'h05);
    ldi(2'd2, 8'h03);
    alu_op(3'b000, 2'd1, 2'd2, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);

    // Signed overflow, then AND R0,R0 (rd==rs) to test overwrite vs sticky
    ldi(2'd0, 8'h7F);
    ldi(2'd1, 8'h01);
    alu_op(3'b000, 2'd0, 2'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    alu_op(3'b001, 2'd0, 2'd0, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0);
    chk("ovf_after_and", overflow_flag, STICKY ? 1'b1 : 1'b0);

    // AND to zero, then NOT of the now-zero R2
    ldi(2'd2, 8'hF0);
    ldi(2'd3, 8'h0F);
    alu_op(3'b001, 2'd2, 2'd3, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0);
    alu_op(3'b010, 2'd2, 2'd0, 8'h00, 8'h80, 8'hFF, 1'b0, 1'b0);

    // Reserved opcode passes through; ALU returns 0
    alu_op(3'b011, 2'd1, 2'd1, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0);

    // LDI waits indefinitely for its immediate
    xfer(8'hF8);
    rdy_cnt = 0;
    wb_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_ready) rdy_cnt++;
      if (wb_valid) wb_cnt++;
    end
    chk("imm_wait_ready", rdy_cnt, 10);
    chk("imm_wait_no_wb", wb_cnt, 0);
    imm_finish(2'd3, 8'h00);

    // Reset during EXEC aborts the ADD
    xfer(8'h0C);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_exec_opcode", alu_opcode, 3'b000);
    chk("pre_rst_zero", zero_flag, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_zero", zero_flag, 1'b0);
    chk("abort_wb", wb_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ovf_model = 1'b0;
    chk("abort_ready", instr_ready, 1'b1);
    chk("abort_ovf", overflow_flag, 1'b0);
    for (int i = 0; i < 4; i++) chk_reg("abort_reg", 2'(i), 8'h00);
    wb_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wb_valid) wb_cnt++;
    end
    chk("abort_no_wb", wb_cnt, 0);

    // Back-to-back ADD R0,R1 with valid held high
    ldi(2'd1, 8'h01);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 8'h02;
    acc_cnt  = 0;
    wb_cnt   = 0;
    last_acc = -4;
    for (int i = 0; i < 41; i++) begin
      if (i == 40) instr_valid = 1'b0;
      if (instr_valid && instr_ready) begin
        chk("b2b_spacing", i - last_acc, 4);
        last_acc = i;
        acc_cnt++;
      end
      if (wb_valid) wb_cnt++;
      @(negedge clk);
    end
    chk("b2b_accepts", acc_cnt, 10);
    chk("b2b_wb_pulses", wb_cnt, 10);
    chk_reg("b2b_r0", 2'd0, 8'h0A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the datapath width.
REQ-002 The block SHALL have parameter NREGS, default 4, the register-file depth (fixed at 4; instr fields are 2 bits).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port instr_valid  input  1  the instruction byte on instr is valid.
REQ-006 The block SHALL have port instr  input  8  {op[7:5], rd[4:3], rs[2:1], 0}, or an immediate byte.
REQ-007 The block SHALL have port instr_ready  output  1  the block accepts instr this cycle.
REQ-008 The block SHALL have port alu_opcode  output  3  opcode to the downstream ALU.
REQ-009 The block SHALL have ports alu_a and alu_b  output  WIDTH  ALU operands.
REQ-010 The block SHALL have ports alu_res  input  WIDTH; alu_zero  input  1; alu_overflow  input  1  combinational ALU results.
REQ-011 The block SHALL have ports wb_valid  output  1; wb_addr  output  2; wb_data  output  WIDTH  one-cycle writeback pulse.
REQ-012 The block SHALL have ports zero_flag and overflow_flag  output  1  registered architectural flags.
REQ-013 The block SHALL have ports dbg_addr  input  2 and dbg_data  output  WIDTH  combinational register-file read.

Function
REQ-014 The FSM SHALL have states IDLE, READ, EXEC, WB, IMM.
REQ-015 instr_ready SHALL be 1 only in IDLE and IMM; a transfer occurs when instr_valid && instr_ready at a rising edge.
REQ-016 IDLE with a transfer of op!=3'b111 SHALL latch op/rd/rs and go to READ; op==3'b111 (LDI) SHALL latch rd and go to IMM.
REQ-017 READ SHALL capture a=R[rd], b=R[rs] into operand registers and go to EXEC.
REQ-018 EXEC SHALL drive alu_opcode=op, alu_a/alu_b from the operand registers, capture alu_res/alu_zero/alu_overflow, and go to WB.
REQ-019 Outside EXEC, alu_opcode SHALL be 3'b000 and alu_a/alu_b SHALL be 0.
REQ-020 WB SHALL write R[rd], assert wb_valid with wb_addr=rd and wb_data=the captured result for exactly one cycle, update the flags, and return to IDLE.
REQ-021 ALU ops SHALL have a latency of 3 cycles from the accepting edge to the write edge; the next instr_ready SHALL be in the cycle after WB.
REQ-022 Opcodes 011-110 SHALL be issued to the ALU unchanged; the ALU result (0) SHALL be written and zero_flag set to 1.
REQ-023 IMM SHALL wait indefinitely for the next transfer, then go to WB with result=instr, zero_flag=(instr==0), and overflow_flag cleared.
REQ-024 Writes to rd==rs SHALL use the pre-write value for operands, because operands are captured in READ.
REQ-025 dbg_data SHALL reflect the post-edge register contents (no bypass).

Reset
REQ-026 rst_n low SHALL immediately force IDLE, all R[i]=0, operand/result registers=0, wb_valid=0, wb_addr=0, wb_data=0, zero_flag=0, overflow_flag=0.
REQ-027 Reset asserted mid-instruction (READ/EXEC/WB/IMM) SHALL abort it with no writeback; instr_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-028 With macro ALU_ISSUE_STICKY_OVF_EN defined, overflow_flag SHALL be sticky: WB ORs in the new overflow, and only reset clears it (LDI does not clear it).
REQ-029 Without ALU_ISSUE_STICKY_OVF_EN, overflow_flag SHALL be overwritten at every WB.

Verification
REQ-030 Reset, then LDI R1,0x05; LDI R2,0x03; ADD R1,R2 -> wb_data=0x08 at wb_addr=1, zero=0, overflow=0, 3 cycles after the ADD is accepted.
REQ-031 R0=0x7F, R1=0x01, ADD R0,R1 -> wb_data=0x80, overflow_flag=1; a following AND R0,R0 -> overflow_flag=0 without the macro and 1 with it.
REQ-032 R2=0xF0, R3=0x0F, AND R2,R3 -> wb_data=0x00, zero_flag=1; NOT R2 -> wb_data=0xFF, zero_flag=0.
REQ-033 LDI R3 accepted, instr_valid held low for 10 cycles -> instr_ready stays 1, no wb_valid; then byte 0x00 -> R3=0x00, zero_flag=1.
REQ-034 rst_n pulsed low during EXEC of ADD -> no wb_valid, all dbg_data=0, flags 0, instr_ready=1 after release.
REQ-035 instr_valid held high continuously with back-to-back ops -> exactly one acceptance per 4 cycles and one wb_valid pulse per op.
